// File: rtl/display_port_if.sv
// CPU-side bus for the display port: write strobe/data in, readback and ack out.
interface display_port_if;
   logic        En;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Ack;

   modport master (output En, output WriteData, input ReadData, input Ack);
   modport slave  (input En, input WriteData, output ReadData, output Ack);
endinterface

// File: rtl/display_port.sv
// Memory-mapped 4-digit multiplexed 7-segment display driver.
// Define DISPLAY_READBACK_EN to expose {mask, value} on ReadData.
module display_port #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic           clk,
   input  logic           rst,
   display_port_if.slave  bus,
   output logic [6:0]     seg,
   output logic [3:0]     an
);
   localparam int unsigned DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

   logic [15:0]   value_q, value_d;
   logic [3:0]    mask_q,  mask_d;
   logic [DW-1:0] div_q,   div_d;
   logic [1:0]    idx_q,   idx_d;
   logic          ack_q,   ack_d;
   logic [6:0]    seg_q,   seg_d;
   logic [3:0]    an_q,    an_d;
   logic          tc;
   logic [3:0]    nib;
   logic          unused_wd;

   // Active-low {g,f,e,d,c,b,a} hex glyphs.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      value_d = value_q;
      mask_d  = mask_q;
      ack_d   = bus.En;
      tc      = (div_q == DIV_LAST);
      div_d   = tc ? '0 : div_q + DW'(1);
      idx_d   = tc ? idx_q + 2'd1 : idx_q;
      nib     = value_q[{idx_q, 2'b00} +: 4];
      seg_d   = 7'h7F;
      an_d    = 4'hF;
      if (bus.En) begin
         value_d = bus.WriteData[15:0];
         mask_d  = bus.WriteData[19:16];
      end
      // Outputs decode the current (pre-edge) index and registers.
      if (mask_q[idx_q]) begin
         seg_d = hex7(nib);
         an_d  = ~(4'b0001 << idx_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= 16'h0000;
         mask_q  <= 4'hF;
         div_q   <= '0;
         idx_q   <= 2'd0;
         ack_q   <= 1'b0;
         seg_q   <= 7'h7F;
         an_q    <= 4'hF;
      end else begin
         value_q <= value_d;
         mask_q  <= mask_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         ack_q   <= ack_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg       = seg_q;
   assign an        = an_q;
   assign bus.Ack   = ack_q;
   assign unused_wd = ^bus.WriteData[31:20];

`ifdef DISPLAY_READBACK_EN
   assign bus.ReadData = {12'h000, mask_q, value_q};
`else
   assign bus.ReadData = 32'h0000_0000;
`endif
endmodule

// File: tb/tb_display_port.sv
// Randomized self-checking bench for display_port against a cycle-count reference model.
module tb_display_port;
   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] seg;
   logic [3:0] an;

   display_port_if bus();

   display_port #(.SCAN_DIV(SD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave),
      .seg (seg),
      .an  (an)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: edges since reset, register image, expected outputs.
   int          n;
   logic [15:0] mval;
   logic [3:0]  mmask;
   logic [6:0]  eseg;
   logic [3:0]  ean;
   logic        eack;
   logic [6:0]  HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   function automatic logic [31:0] exp_rd();
`ifdef DISPLAY_READBACK_EN
      return {12'h000, mmask, mval};
`else
      return 32'h0;
`endif
   endfunction

   // Drive one cycle, advance the model by one edge, settle past the edge.
   task automatic step(input logic r, input logic e, input logic [31:0] wd);
      int d;
      rst = r; bus.En = e; bus.WriteData = wd;
      @(posedge clk);
      if (r) begin
         n = 0; mval = 16'h0; mmask = 4'hF; eseg = 7'h7F; ean = 4'hF; eack = 1'b0;
      end else begin
         d = (n / SD) % 4;
         if (mmask[d]) begin
            eseg = HEX[mval[d*4 +: 4]];
            ean  = ~(4'b0001 << d);
         end else begin
            eseg = 7'h7F;
            ean  = 4'hF;
         end
         eack = e;
         if (e) begin
            mval  = wd[15:0];
            mmask = wd[19:16];
         end
         n++;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 32'h0);
         checks++;
         if (seg !== 7'h7F || an !== 4'hF || bus.Ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: seg=%b an=%b ack=%b, want seg=1111111 an=1111 ack=0", seg, an, bus.Ack);
         end
      end
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (seg !== 7'b1000000 || an !== 4'b1110 || bus.Ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: seg=%b an=%b ack=%b, want seg=1000000 an=1110 ack=0", seg, an, bus.Ack);
      end
   endtask

   task automatic test_scan();
      logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      logic [6:0] sg_seq [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
      int hits = 0;
      step(1'b0, 1'b1, 32'h000F_1234);
      checks++;
      if (bus.Ack !== 1'b1) begin
         errors++; $display("FAIL scan_ack_hi: ack=%b want 1", bus.Ack);
      end
      step(1'b0, 1'b0, $urandom);
      checks++;
      if (bus.Ack !== 1'b0) begin
         errors++; $display("FAIL scan_ack_lo: ack=%b want 0", bus.Ack);
      end
      for (int i = 0; i < 5 * SD; i++) begin
         step(1'b0, 1'b0, $urandom);
         checks++;
         if (seg !== eseg || an !== ean || bus.Ack !== eack) begin
            errors++;
            $display("FAIL scan_cycle%0d: seg=%b an=%b ack=%b, want seg=%b an=%b ack=%b",
                     i, seg, an, bus.Ack, eseg, ean, eack);
         end
         for (int k = 0; k < 4; k++)
            if (an === an_seq[k] && seg === sg_seq[k]) hits++;
      end
      checks++;
      if (hits < 4 * SD) begin
         errors++; $display("FAIL scan_digits: matched %0d cycles, want at least %0d", hits, 4 * SD);
      end
   endtask

   task automatic test_blanking();
      int blanks = 0;
      step(1'b0, 1'b1, 32'h0005_ABCD);
      for (int i = 0; i < 5 * SD; i++) begin
         step(1'b0, 1'b0, 32'h0);
         checks++;
         if (seg !== eseg || an !== ean) begin
            errors++;
            $display("FAIL blank_cycle%0d: seg=%b an=%b, want seg=%b an=%b", i, seg, an, eseg, ean);
         end
         if (an === 4'hF && seg === 7'h7F) blanks++;
         if (an === 4'b1101 || an === 4'b0111) begin
            checks++; errors++;
            $display("FAIL blank_digit: an=%b, blanked digits must not be selected", an);
         end
      end
      checks++;
      if (blanks < 2 * SD) begin
         errors++; $display("FAIL blank_count: %0d blank cycles, want at least %0d", blanks, 2 * SD);
      end
   endtask

   task automatic test_collision();
      logic [31:0] wd;
      while (n % SD != SD - 1) step(1'b0, 1'b0, 32'h0);
      wd = {$urandom} | 32'h000F_0000;
      step(1'b0, 1'b1, wd);
      checks++;
      if (bus.Ack !== 1'b1 || bus.ReadData !== exp_rd()) begin
         errors++;
         $display("FAIL coll_tc_write: ack=%b rd=%h, want ack=1 rd=%h", bus.Ack, bus.ReadData, exp_rd());
      end
      for (int i = 0; i < 2 * SD; i++) begin
         step(1'b0, 1'b0, 32'h0);
         checks++;
         if (seg !== eseg || an !== ean) begin
            errors++;
            $display("FAIL coll_tc_cycle%0d: seg=%b an=%b, want seg=%b an=%b", i, seg, an, eseg, ean);
         end
      end
      step(1'b1, 1'b1, 32'h0003_9876);
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (bus.Ack !== 1'b0 || seg !== 7'b1000000 || an !== 4'b1110 || bus.ReadData !== exp_rd()) begin
         errors++;
         $display("FAIL coll_rst_en: ack=%b seg=%b an=%b rd=%h, want ack=0 seg=1000000 an=1110 rd=%h",
                  bus.Ack, seg, an, bus.ReadData, exp_rd());
      end
   endtask

   task automatic test_readback();
      logic [31:0] want;
`ifdef DISPLAY_READBACK_EN
      want = 32'h000A_5A5A;
`else
      want = 32'h0;
`endif
      step(1'b0, 1'b1, 32'hFFFA_5A5A);
      checks++;
      if (bus.ReadData !== want) begin
         errors++; $display("FAIL readback_fixed: rd=%h want %h", bus.ReadData, want);
      end
      step(1'b0, 1'b1, 32'h1234_5678);
      checks++;
      if (bus.ReadData !== exp_rd() || bus.Ack !== 1'b1) begin
         errors++;
         $display("FAIL readback_b2b: rd=%h ack=%b, want rd=%h ack=1", bus.ReadData, bus.Ack, exp_rd());
      end
   endtask

   task automatic test_random();
      logic r, e;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 49) == 0);
         e = ($urandom_range(0, 3) == 0);
         step(r, e, $urandom);
         checks++;
         if (seg !== eseg || an !== ean || bus.Ack !== eack || bus.ReadData !== exp_rd()) begin
            errors++;
            $display("FAIL random_cycle%0d: seg=%b an=%b ack=%b rd=%h, want seg=%b an=%b ack=%b rd=%h",
                     i, seg, an, bus.Ack, bus.ReadData, eseg, ean, eack, exp_rd());
         end
      end
   endtask

   initial begin
      bus.En = 1'b0;
      bus.WriteData = 32'h0;
      test_reset();
      test_scan();
      test_blanking();
      test_collision();
      test_readback();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
